mul8_seq_ctrl: RTL and testbench
================================

MUL8_SEQ_CTRL -- requirements
Module: mul8_seq_ctrl

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter OPS_W, default 16, width of the completed-operation counter.
REQ-003 Port clk, input, 1, rising-edge clock for all state.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port in_valid, input, 1, requester presents operands.
REQ-006 Port in_ready, output, 1, block accepts operands this cycle.
REQ-007 Port a, input, 8, unsigned multiplicand.
REQ-008 Port b, input, 8, unsigned multiplier.
REQ-009 Port out_valid, output, 1, prod holds a finished result.
REQ-010 Port out_ready, input, 1, consumer takes the result this cycle.
REQ-011 Port prod, output, 16, unsigned product a*b.
REQ-012 Port busy, output, 1, high in any state except IDLE.
REQ-013 Port ops_count, output, OPS_W, number of results delivered, modulo 2^OPS_W.

Function
REQ-014 SHALL compute the 8x8 unsigned product by time-sharing one 4x4 combinational multiplier over four steps.
REQ-015 States SHALL be IDLE, MUL and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE and SHALL depend on state alone, with no combinational path from any input.
REQ-017 In IDLE, on an edge with in_valid=1:
- latch a and b into operand registers
- clear the accumulator to 0
- set step to 0
- go to MUL
REQ-018 In MUL, each edge SHALL add the partial product for the current step to the accumulator, then increment step. Partial products by step:
- step 0: a[3:0]*b[3:0], shift 0
- step 1: a[7:4]*b[3:0], shift 4
- step 2: a[3:0]*b[7:4], shift 4
- step 3: a[7:4]*b[7:4], shift 8
REQ-019 After the step-3 edge the FSM SHALL enter DONE; out_valid SHALL rise exactly 4 edges after the accepting edge.
REQ-020 The accumulator SHALL be 16 bits; no overflow is possible and no truncation SHALL occur.
REQ-021 In DONE:
- out_valid=1 and prod=accumulator
- prod SHALL stay stable while out_ready=0, for an unbounded number of cycles
REQ-022 In DONE with out_ready=1, the edge SHALL:
- return the FSM to IDLE
- increment ops_count, wrapping from 2^OPS_W-1 to 0
REQ-023 No new operands SHALL be accepted in MUL or DONE; in_valid there SHALL have no effect. Operand changes after acceptance SHALL not affect the result.
REQ-024 Minimum initiation interval SHALL be 6 cycles: accept, 4 MUL cycles, 1 DONE cycle with out_ready=1.
REQ-025 prod SHALL read 0 whenever out_valid=0.

Reset
REQ-026 Reset SHALL take priority over all other events, including a handshake on the same edge.
REQ-027 On reset:
- state=IDLE, step=0, accumulator=0, operand registers=0
- in_ready=1, out_valid=0, busy=0, prod=0, ops_count=0
REQ-028 Reset during MUL or DONE SHALL abandon the operation with no result delivered and no ops_count increment.

Structure
REQ-029 Package mul_seq_pkg SHALL hold:
- state encoding type
- step width (2)
- operand width (8) and product width (16)
REQ-030 Exactly one instance of the team's 4x4 Wallace multiplier, module wallace, SHALL be used; the controller drives its nibble operand muxes from step.
REQ-031 The shift, accumulate and FSM logic SHALL reside in mul8_seq_ctrl; no further sub-modules.

Verification
REQ-032 a=0x12, b=0x34, out_ready=1 -> out_valid rises 4 edges after accept, prod=0x03A8, ops_count=1.
REQ-033 a=0xFF, b=0xFF -> prod=0xFE01; a=0x00, b=0xA7 -> prod=0x0000.
REQ-034 a=0xA5, b=0x5A, out_ready held 0 for 10 cycles -> prod=0x3A02 stable and in_ready=0 throughout; release -> IDLE next edge.
REQ-035 rst asserted on the 2nd MUL cycle -> next cycle all outputs at reset values, then a new request 0x03*0x07 gives prod=0x0015.
REQ-036 Back-to-back requests with in_valid held high, OPS_W=2, 5 operations -> 6-cycle spacing, operands changed after accept ignored, ops_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared types and widths for the sequential 8x8 multiplier controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mul_seq_pkg;

    localparam int STEP_W = 2;
    localparam int OPND_W = 8;
    localparam int PROD_W = 16;
    localparam int NIB_W  = OPND_W / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Left shift applied to a step's partial product. Step bit 0 selects the
    // high multiplicand nibble and step bit 1 the high multiplier nibble, so
    // each selected high nibble contributes 4 bits of shift: 0, 4, 4, 8.
    function automatic logic [3:0] step_shift(input logic [STEP_W-1:0] step);
        return {step[1] & step[0], step[1] ^ step[0], 2'b00};
    endfunction

endpackage

// File: rtl/wallace.sv
// 4x4 unsigned combinational multiplier built as a carry-save (Wallace) tree.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the inputs.
module wallace (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    logic [7:0] row0, row1, row2, row3;
    logic [7:0] sum1, cry1, sum2, cry2;

    // Partial-product rows, one per multiplier bit, pre-shifted into place.
    always_comb begin
        row0 = {4'b0000, a & {4{b[0]}}};
        row1 = {3'b000, a & {4{b[1]}}, 1'b0};
        row2 = {2'b00, a & {4{b[2]}}, 2'b00};
        row3 = {1'b0, a & {4{b[3]}}, 3'b000};
    end

    // Two 3:2 compression layers, then one carry-propagate add. Carries out
    // of bit 7 are always zero because the product of two nibbles is < 256.
    always_comb begin
        sum1 = row0 ^ row1 ^ row2;
        cry1 = {((row0[6:0] & row1[6:0]) | (row0[6:0] & row2[6:0]) | (row1[6:0] & row2[6:0])), 1'b0};
        sum2 = sum1 ^ cry1 ^ row3;
        cry2 = {((sum1[6:0] & cry1[6:0]) | (sum1[6:0] & row3[6:0]) | (cry1[6:0] & row3[6:0])), 1'b0};
        p    = sum2 + cry2;
    end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// 8x8 unsigned multiplier that reuses one 4x4 multiplier over four steps.
// Latency: result valid 4 edges after the accepting edge; 6-cycle minimum initiation interval.
// Backpressure: result held in DONE while out_ready=0; in_ready is low until the result is taken.
module mul8_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int OPS_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      prod,
    output logic             busy,
    output logic [OPS_W-1:0] ops_count
);

    localparam logic [OPS_W-1:0]  OPS_ONE   = 1;
    localparam logic [STEP_W-1:0] STEP_LAST = 2'd3;

    state_t              state, next_state;
    logic [STEP_W-1:0]   step;
    logic [OPND_W-1:0]   op_a, op_b;
    logic [PROD_W-1:0]   acc;
    logic [NIB_W-1:0]    nib_a, nib_b;
    logic [2*NIB_W-1:0]  pp;
    logic [PROD_W-1:0]   pp_shifted;

    // Nibble selection for the shared multiplier: step[0] picks the high
    // multiplicand nibble, step[1] the high multiplier nibble.
    always_comb begin
        nib_a      = step[0] ? op_a[7:4] : op_a[3:0];
        nib_b      = step[1] ? op_b[7:4] : op_b[3:0];
        pp_shifted = PROD_W'(pp) << step_shift(step);
    end

    wallace u_wallace (
        .a (nib_a),
        .b (nib_b),
        .p (pp)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs; all outputs depend on state alone
    // except next_state, so in_ready has no combinational input path.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) next_state = MUL;
            end
            MUL: begin
                if (step == STEP_LAST) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one partial-product accumulate per MUL edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a <= '0;
            op_b <= '0;
            acc  <= '0;
            step <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a <= a;
                        op_b <= b;
                        acc  <= '0;
                        step <= '0;
                    end
                end
                MUL: begin
                    acc  <= acc + pp_shifted;
                    step <= step + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Count delivered results; wraps naturally at 2^OPS_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_count <= '0;
        end else if (state == DONE && out_ready) begin
            ops_count <= ops_count + OPS_ONE;
        end
    end

    // Product is only exposed while a result is on offer.
    always_comb begin
        prod = out_valid ? acc : '0;
    end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Self-checking bench for mul8_seq_ctrl with a cycle-level behavioural model.
// Latency: not applicable.
// Backpressure: exercised through out_ready holds and back-to-back requests.
module tb_mul8_seq_ctrl;

    localparam int OPS_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       a = 8'h00;
    logic [7:0]       b = 8'h00;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      prod;
    logic             busy;
    logic [OPS_W-1:0] ops_count;

    int vec_cnt  = 0;
    int fail_cnt = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    mul8_seq_ctrl #(.OPS_W(OPS_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .busy      (busy),
        .ops_count (ops_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Behavioural model: m_left counts MUL edges still to go after an accept;
    // m_done marks a result on offer.
    bit               m_busy = 1'b0;
    bit               m_done = 1'b0;
    int               m_left = 0;
    logic [15:0]      m_prod = 16'h0;
    logic [OPS_W-1:0] m_ops  = '0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_left = 0;
            m_ops  = '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_prod = 16'(a) * 16'(b);
                m_busy = 1'b1;
                m_left = 4;
            end
        end else if (!m_done) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (out_ready) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_ops  = m_ops + 1'b1;
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_in_ready",  32'(in_ready),  32'(!m_busy));
            chk("model_busy",      32'(busy),      32'(m_busy));
            chk("model_out_valid", 32'(out_valid), 32'(m_done));
            chk("model_prod",      32'(prod),      m_done ? 32'(m_prod) : 32'h0);
            chk("model_ops_count", 32'(ops_count), 32'(m_ops));
        end
    end

    // Called right after an accepting edge; returns edges until out_valid.
    // Operands are scrambled every cycle to show they are not re-sampled.
    task automatic wait_valid(input bit drop_valid, output int lat);
        @(negedge clk);
        lat = 0;
        if (drop_valid) in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            a = 8'($urandom);
            b = 8'($urandom);
        end
        if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                          input logic [15:0] exp, input int hold);
        int lat;
        @(negedge clk);
        chk("in_ready_before", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        a         = va;
        b         = vb;
        out_ready = (hold == 0);
        @(posedge clk);
        wait_valid(1'b1, lat);
        chk("latency", 32'(lat), 32'd4);
        chk("prod_literal", 32'(prod), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("prod_held", 32'(prod), 32'(exp));
            chk("in_ready_held", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_after", 32'(in_ready), 32'd1);
        chk("out_valid_after", 32'(out_valid), 32'd0);
    endtask

    logic [7:0]       bb_a   [5] = '{8'h12, 8'hFF, 8'h00, 8'hA5, 8'h0F};
    logic [7:0]       bb_b   [5] = '{8'h34, 8'hFF, 8'hA7, 8'h5A, 8'h10};
    logic [15:0]      bb_exp [5] = '{16'h03A8, 16'hFE01, 16'h0000, 16'h3A02, 16'h00F0};
    logic [OPS_W-1:0] bb_ops [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    int               acc_cyc[5];

    initial begin
        int lat;
        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_prod",      32'(prod),      32'd0);
        chk("rst_ops_count", 32'(ops_count), 32'd0);
        rst = 1'b0;

        // Basic products and a held result.
        run_op(8'h12, 8'h34, 16'h03A8, 0);
        chk("ops_after_first", 32'(ops_count), 32'd1);
        run_op(8'hFF, 8'hFF, 16'hFE01, 0);
        run_op(8'h00, 8'hA7, 16'h0000, 0);
        run_op(8'hA5, 8'h5A, 16'h3A02, 10);

        // Reset on the second MUL cycle abandons the operation.
        @(negedge clk);
        in_valid  = 1'b1;
        a         = 8'hA5;
        b         = 8'h5A;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_busy",      32'(busy),      32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_prod",      32'(prod),      32'd0);
        chk("midrst_ops_count", 32'(ops_count), 32'd0);
        rst = 1'b0;
        run_op(8'h03, 8'h07, 16'h0015, 0);
        chk("ops_after_midrst", 32'(ops_count), 32'd1);

        // Reset wins over a delivery handshake on the same edge.
        @(negedge clk);
        in_valid  = 1'b1;
        a         = 8'h12;
        b         = 8'h34;
        out_ready = 1'b0;
        @(posedge clk);
        wait_valid(1'b1, lat);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rstwin_ops_count", 32'(ops_count), 32'd0);
        chk("rstwin_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;

        // Back-to-back with in_valid held high throughout.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            int t = 0;
            while (!in_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) chk("b2b_ready_timeout", 32'(in_ready), 32'd1);
            a = bb_a[i];
            b = bb_b[i];
            acc_cyc[i] = cyc;
            @(posedge clk);
            wait_valid(1'b0, lat);
            chk("b2b_latency", 32'(lat), 32'd4);
            chk("b2b_prod", 32'(prod), 32'(bb_exp[i]));
            @(negedge clk);
            chk("b2b_ops_count", 32'(ops_count), 32'(bb_ops[i]));
            if (i > 0) chk("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd6);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
